corexy_move_sequencer: RTL and testbench

- Upstream neighbour of the CoreXY dual-stepper driver.
- Buffers move commands {step_1, speed_1, step_2, speed_2} arriving from the UART command parser in a FIFO.
- Presents one command at a time to the driver and runs the driver's start_driving / steppers_driving handshake.
- Detects endstop-truncated moves, flushes the queue on them, and reports status.

---
 rtl/corexy_pkg.sv | 30 +++
 rtl/move_cmd_fifo.sv | 60 ++++++
 rtl/corexy_move_sequencer.sv | 142 ++++++++++++++
 tb/tb_corexy_move_sequencer.sv | 376 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/corexy_pkg.sv
// Shared types for the CoreXY move sequencer: the queued move command,
// the sequencer states and the step-word encoding helpers.
package corexy_pkg;

    localparam int unsigned STEP_W       = 32;
    localparam int unsigned STEP_DIR_BIT = 31;
    localparam int unsigned MOVES_W      = 16;

    typedef struct packed {
        logic [STEP_W-1:0] step_1;
        logic [STEP_W-1:0] speed_1;
        logic [STEP_W-1:0] step_2;
        logic [STEP_W-1:0] speed_2;
    } move_cmd_t;

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        WAIT_BUSY,
        RUN,
        CHECK,
        GAP
    } seq_state_t;

    // Magnitude is zero when nothing survives once the direction bit is shifted out.
    function automatic logic step_mag_zero(input logic [STEP_W-1:0] step);
        return (step << 1) == '0;
    endfunction

endpackage

// File: rtl/move_cmd_fifo.sv
// First-word-fall-through FIFO of move commands with synchronous flush;
// the head entry is visible on rd_data whenever the FIFO is non-empty.
module move_cmd_fifo
    import corexy_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic                  pop,
    input  logic                  flush,
    input  move_cmd_t             wr_data,
    output move_cmd_t             rd_data,
    output logic                  full_c,
    output logic                  empty_c,
    output logic [$clog2(DEPTH):0] count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    move_cmd_t     mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full_c  = (count == CW'(DEPTH));
    assign empty_c = (count == '0);
    assign do_push = push && !full_c && !flush;
    assign do_pop  = pop && !empty_c && !flush;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage carries no reset; only entries behind a valid count are ever read.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/corexy_move_sequencer.sv
// Queues CoreXY move commands and hands them one at a time to the dual-stepper
// driver over the start_driving / steppers_driving handshake.
module corexy_move_sequencer
    import corexy_pkg::*;
#(
    parameter int unsigned DEPTH        = 8,
    parameter int unsigned BUSY_TIMEOUT = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [STEP_W-1:0]      cmd_step_1,
    input  logic [STEP_W-1:0]      cmd_speed_1,
    input  logic [STEP_W-1:0]      cmd_step_2,
    input  logic [STEP_W-1:0]      cmd_speed_2,
    input  logic                   flush,
    input  logic                   clear_status,
    input  logic                   steppers_driving,
    input  logic [STEP_W-1:0]      stepper_step_out_1,
    input  logic [STEP_W-1:0]      stepper_step_out_2,
    output logic [STEP_W-1:0]      stepper_step_in_1,
    output logic [STEP_W-1:0]      stepper_speed_1,
    output logic [STEP_W-1:0]      stepper_step_in_2,
    output logic [STEP_W-1:0]      stepper_speed_2,
    output logic                   start_driving,
    output logic                   busy,
    output logic [$clog2(DEPTH):0] fifo_count,
    output logic [MOVES_W-1:0]     moves_done,
    output logic                   endstop_hit,
    output logic                   start_fail
);

    localparam int unsigned TW = $clog2(BUSY_TIMEOUT + 1);

    seq_state_t    state;
    logic [TW-1:0] timer;
    move_cmd_t     wr_cmd;
    move_cmd_t     head;
    logic          fifo_full_c;
    logic          fifo_empty_c;
    logic          pop_c;
    logic          truncated_c;
    logic          fifo_flush_c;
    logic          head_null_c;

    assign wr_cmd       = '{step_1: cmd_step_1, speed_1: cmd_speed_1,
                            step_2: cmd_step_2, speed_2: cmd_speed_2};
    assign cmd_ready    = !fifo_full_c;
    assign busy         = (state != IDLE) || !fifo_empty_c;
    assign pop_c        = (state == IDLE) && !fifo_empty_c && !flush;
    assign head_null_c  = step_mag_zero(head.step_1) && step_mag_zero(head.step_2);
    assign truncated_c  = !step_mag_zero(stepper_step_out_1) || !step_mag_zero(stepper_step_out_2);
    assign fifo_flush_c = flush || ((state == CHECK) && truncated_c);

    move_cmd_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (cmd_valid),
        .pop     (pop_c),
        .flush   (fifo_flush_c),
        .wr_data (wr_cmd),
        .rd_data (head),
        .full_c  (fifo_full_c),
        .empty_c (fifo_empty_c),
        .count   (fifo_count)
    );

    // Handshake sequencer; sticky-flag clears come first so a same-cycle set wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state             <= IDLE;
            timer             <= '0;
            start_driving     <= 1'b0;
            stepper_step_in_1 <= '0;
            stepper_speed_1   <= '0;
            stepper_step_in_2 <= '0;
            stepper_speed_2   <= '0;
            moves_done        <= '0;
            endstop_hit       <= 1'b0;
            start_fail        <= 1'b0;
        end else begin
            if (clear_status) begin
                endstop_hit <= 1'b0;
                start_fail  <= 1'b0;
            end
            if (flush) begin
                state         <= IDLE;
                start_driving <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (!fifo_empty_c) begin
                            stepper_step_in_1 <= head.step_1;
                            stepper_speed_1   <= head.speed_1;
                            stepper_step_in_2 <= head.step_2;
                            stepper_speed_2   <= head.speed_2;
                            if (head_null_c) moves_done <= moves_done + MOVES_W'(1);
                            else             state      <= ARM;
                        end
                    end
                    ARM: begin
                        start_driving <= 1'b1;
                        timer         <= '0;
                        state         <= WAIT_BUSY;
                    end
                    WAIT_BUSY: begin
                        if (steppers_driving) begin
                            state <= RUN;
                        end else if (timer == TW'(BUSY_TIMEOUT - 1)) begin
                            start_fail    <= 1'b1;
                            start_driving <= 1'b0;
                            state         <= IDLE;
                        end else begin
                            timer <= timer + TW'(1);
                        end
                    end
                    RUN: begin
                        if (!steppers_driving) begin
                            start_driving <= 1'b0;
                            state         <= CHECK;
                        end
                    end
                    CHECK: begin
                        if (truncated_c) begin
                            endstop_hit <= 1'b1;
                            state       <= IDLE;
                        end else begin
                            moves_done <= moves_done + MOVES_W'(1);
                            state      <= GAP;
                        end
                    end
                    GAP:     state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_corexy_move_sequencer.sv
// Directed/randomised bench for corexy_move_sequencer: a behavioural stepper
// driver and a queue scoreboard of expected moves in issue order.
module tb_corexy_move_sequencer;
    import corexy_pkg::*;

    localparam int DRV_NORMAL = 0;
    localparam int DRV_STALL  = 1;
    localparam int DRV_TRUNC  = 2;
    localparam int DRV_HOLD   = 3;
    localparam int W_IDLE     = 0;
    localparam int W_ENDSTOP  = 1;
    localparam int W_FAIL     = 2;
    localparam int W_RUN      = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] cmd_step_1, cmd_speed_1, cmd_step_2, cmd_speed_2;
    logic        flush, clear_status, steppers_driving;
    logic [31:0] stepper_step_out_1, stepper_step_out_2;
    logic [31:0] stepper_step_in_1, stepper_speed_1, stepper_step_in_2, stepper_speed_2;
    logic        start_driving, busy;
    logic [3:0]  fifo_count;
    logic [15:0] moves_done;
    logic        endstop_hit, start_fail;

    int errors = 0;
    int checks = 0;
    move_cmd_t exp_q[$];
    int exp_done = 0;
    int drv_mode = DRV_NORMAL;
    int drv_lat = 1;
    int drv_len = 3;
    int low_run = 1000;
    int high_run = 0;
    int last_high_len = 0;

    always #5 clk = ~clk;

    corexy_move_sequencer #(.DEPTH(8), .BUSY_TIMEOUT(16)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_step_1(cmd_step_1), .cmd_speed_1(cmd_speed_1),
        .cmd_step_2(cmd_step_2), .cmd_speed_2(cmd_speed_2),
        .flush(flush), .clear_status(clear_status), .steppers_driving(steppers_driving),
        .stepper_step_out_1(stepper_step_out_1), .stepper_step_out_2(stepper_step_out_2),
        .stepper_step_in_1(stepper_step_in_1), .stepper_speed_1(stepper_speed_1),
        .stepper_step_in_2(stepper_step_in_2), .stepper_speed_2(stepper_speed_2),
        .start_driving(start_driving), .busy(busy), .fifo_count(fifo_count),
        .moves_done(moves_done), .endstop_hit(endstop_hit), .start_fail(start_fail)
    );

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // A move with no steps on either motor: magnitude is the word modulo 2^31.
    function automatic bit is_null_move(input move_cmd_t c);
        return ((c.step_1 % 32'h8000_0000) == 0) && ((c.step_2 % 32'h8000_0000) == 0);
    endfunction

    function automatic move_cmd_t rnd_cmd();
        move_cmd_t c;
        c.step_1  = $urandom;
        c.step_2  = $urandom;
        c.speed_1 = $urandom_range(1, 200);
        c.speed_2 = $urandom_range(1, 200);
        if ((c.step_1 % 32'h8000_0000) == 0) c.step_1 = c.step_1 + 1;
        return c;
    endfunction

    function automatic move_cmd_t mk(input logic [31:0] s1, input logic [31:0] v1,
                                     input logic [31:0] s2, input logic [31:0] v2);
        move_cmd_t c;
        c.step_1 = s1; c.speed_1 = v1; c.step_2 = s2; c.speed_2 = v2;
        return c;
    endfunction

    task automatic push_cmd(input move_cmd_t c, input logic exp_accept);
        @(negedge clk);
        cmd_valid   = 1'b1;
        cmd_step_1  = c.step_1;
        cmd_speed_1 = c.speed_1;
        cmd_step_2  = c.step_2;
        cmd_speed_2 = c.speed_2;
        check("push_ready", 32'(cmd_ready), 32'(exp_accept));
        if (exp_accept) exp_q.push_back(c);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_cond(input int which, input string tag);
        int  n;
        logic hit;
        n = 0;
        hit = 1'b0;
        while (!hit && n < 3000) begin
            @(posedge clk); #1;
            n++;
            case (which)
                W_IDLE:    hit = !busy && !start_driving;
                W_ENDSTOP: hit = endstop_hit;
                W_FAIL:    hit = start_fail;
                default:   hit = steppers_driving;
            endcase
        end
        check(tag, 32'(hit), 32'd1);
    endtask

    task automatic pulse_clear();
        @(negedge clk);
        clear_status = 1'b1;
        @(posedge clk); #1;
        clear_status = 1'b0;
    endtask

    // Behavioural stepper driver: answers start_driving after drv_lat cycles,
    // runs drv_len cycles, and reports remaining steps when it stops.
    initial begin : driver_model
        int st;
        int cnt;
        st = 0;
        cnt = 0;
        steppers_driving   = 1'b0;
        stepper_step_out_1 = '0;
        stepper_step_out_2 = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                st = 0;
                steppers_driving   = 1'b0;
                stepper_step_out_1 = '0;
                stepper_step_out_2 = '0;
            end else begin
                case (st)
                    0: if (start_driving && drv_mode != DRV_STALL) begin
                        cnt = drv_lat;
                        st  = 1;
                    end
                    1: if (!start_driving) st = 0;
                       else if (cnt == 0) begin
                           steppers_driving   = 1'b1;
                           stepper_step_out_1 = 32'd7;
                           stepper_step_out_2 = 32'd7;
                           cnt = drv_len;
                           st  = 2;
                       end else cnt--;
                    2: if (!start_driving) begin
                           steppers_driving = 1'b0;
                           st = 0;
                       end else if (drv_mode != DRV_HOLD) begin
                           if (cnt == 0) begin
                               steppers_driving   = 1'b0;
                               stepper_step_out_2 = 32'h8000_0000;
                               if (drv_mode == DRV_TRUNC) stepper_step_out_1 = 32'd3;
                               else begin
                                   stepper_step_out_1 = 32'h8000_0000;
                                   exp_done++;
                               end
                               st = 3;
                           end else cnt--;
                       end
                    default: if (!start_driving) st = 0;
                endcase
            end
        end
    end

    // Scoreboard: every start must present the next non-null queued move.
    initial begin : monitor
        logic      prev_sd;
        move_cmd_t c;
        prev_sd = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (!rst_n) begin
                prev_sd  = 1'b0;
                low_run  = 1000;
                high_run = 0;
            end else begin
                if (start_driving && !prev_sd) begin
                    check("start_gap_ge2", 32'(low_run >= 2), 32'd1);
                    while (exp_q.size() > 0 && is_null_move(exp_q[0])) begin
                        void'(exp_q.pop_front());
                        exp_done++;
                    end
                    check("start_expected", 32'(exp_q.size() != 0), 32'd1);
                    if (exp_q.size() != 0) begin
                        c = exp_q.pop_front();
                        check("step_in_1", stepper_step_in_1, c.step_1);
                        check("speed_1", stepper_speed_1, c.speed_1);
                        check("step_in_2", stepper_step_in_2, c.step_2);
                        check("speed_2", stepper_speed_2, c.speed_2);
                    end
                end
                if (start_driving) begin
                    if (!prev_sd) high_run = 0;
                    high_run++;
                end else begin
                    if (prev_sd) begin
                        last_high_len = high_run;
                        low_run = 0;
                    end
                    low_run++;
                end
                prev_sd = start_driving;
            end
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        move_cmd_t c;
        int        base;
        rst_n = 1'b1;
        cmd_valid = 1'b0; flush = 1'b0; clear_status = 1'b0;
        cmd_step_1 = '0; cmd_speed_1 = '0; cmd_step_2 = '0; cmd_speed_2 = '0;
        #2 rst_n = 1'b0;
        #1;
        check("rst_start_driving", 32'(start_driving), 32'd0);
        check("rst_step_in_1", stepper_step_in_1, 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst_fifo_count", 32'(fifo_count), 32'd0);
        check("rst_moves_done", 32'(moves_done), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_flags", 32'({endstop_hit, start_fail}), 32'd0);

        // Single move with mixed directions
        drv_mode = DRV_NORMAL; drv_lat = 2; drv_len = 5;
        push_cmd(mk(32'd10, 32'd4, 32'h8000_0005, 32'd4), 1'b1);
        wait_cond(W_IDLE, "t1_idle");
        check("t1_moves_done", 32'(moves_done), 32'(exp_done));
        check("t1_moves_is_one", 32'(exp_done), 32'd1);
        check("t1_endstop", 32'(endstop_hit), 32'd0);
        check("t1_hold_step_in_2", stepper_step_in_2, 32'h8000_0005);

        // Fill the queue behind a held move; ninth push must be refused
        drv_mode = DRV_HOLD;
        push_cmd(rnd_cmd(), 1'b1);
        wait_cond(W_RUN, "t2_running");
        for (int i = 0; i < 8; i++) push_cmd(rnd_cmd(), 1'b1);
        push_cmd(rnd_cmd(), 1'b0);
        check("t2_fifo_full_count", 32'(fifo_count), 32'd8);
        base = exp_done;
        drv_mode = DRV_NORMAL;
        wait_cond(W_IDLE, "t2_idle");
        check("t2_moves_done", 32'(moves_done), 32'(exp_done));
        check("t2_nine_moves", 32'(exp_done - base), 32'd9);
        check("t2_queue_drained", 32'(exp_q.size()), 32'd0);

        // Null move is dropped, counted, and the next one starts
        base = exp_done;
        push_cmd(mk(32'd0, 32'd5, 32'h8000_0000, 32'd5), 1'b1);
        push_cmd(rnd_cmd(), 1'b1);
        wait_cond(W_IDLE, "t3_idle");
        check("t3_moves_done", 32'(moves_done), 32'(exp_done));
        check("t3_two_counted", 32'(exp_done - base), 32'd2);
        check("t3_queue_drained", 32'(exp_q.size()), 32'd0);

        // Endstop truncation flushes the two queued moves
        drv_mode = DRV_TRUNC;
        for (int i = 0; i < 3; i++) push_cmd(rnd_cmd(), 1'b1);
        wait_cond(W_ENDSTOP, "t4_endstop");
        check("t4_fifo_flushed", 32'(fifo_count), 32'd0);
        check("t4_moves_unchanged", 32'(moves_done), 32'(exp_done));
        check("t4_start_low", 32'(start_driving), 32'd0);
        wait_cond(W_IDLE, "t4_idle");
        check("t4_endstop_sticky", 32'(endstop_hit), 32'd1);
        exp_q.delete();
        drv_mode = DRV_NORMAL;
        pulse_clear();
        check("t4_endstop_cleared", 32'(endstop_hit), 32'd0);

        // Driver never answers: timeout, then the next move is attempted
        drv_mode = DRV_STALL;
        push_cmd(rnd_cmd(), 1'b1);
        push_cmd(rnd_cmd(), 1'b1);
        wait_cond(W_FAIL, "t5_start_fail");
        @(negedge clk);
        check("t5_start_low", 32'(start_driving), 32'd0);
        check("t5_high_cycles", 32'(last_high_len), 32'd16);
        drv_mode = DRV_NORMAL;
        wait_cond(W_IDLE, "t5_idle");
        check("t5_moves_done", 32'(moves_done), 32'(exp_done));
        check("t5_queue_drained", 32'(exp_q.size()), 32'd0);
        check("t5_fail_sticky", 32'(start_fail), 32'd1);
        pulse_clear();
        check("t5_fail_cleared", 32'(start_fail), 32'd0);

        // Flush mid-run together with a push
        drv_mode = DRV_HOLD;
        for (int i = 0; i < 3; i++) push_cmd(rnd_cmd(), 1'b1);
        wait_cond(W_RUN, "t6_running");
        repeat (2) @(posedge clk);
        base = exp_done;
        c = rnd_cmd();
        @(negedge clk);
        flush = 1'b1; cmd_valid = 1'b1;
        cmd_step_1 = c.step_1; cmd_speed_1 = c.speed_1;
        cmd_step_2 = c.step_2; cmd_speed_2 = c.speed_2;
        @(posedge clk); #1;
        flush = 1'b0; cmd_valid = 1'b0;
        check("t6_start_low", 32'(start_driving), 32'd0);
        check("t6_fifo_empty", 32'(fifo_count), 32'd0);
        exp_q.delete();
        drv_mode = DRV_NORMAL;
        repeat (10) @(posedge clk);
        #1;
        check("t6_push_lost", 32'(busy), 32'd0);
        check("t6_moves_unchanged", 32'(moves_done), 32'(base));
        check("t6_flags_unchanged", 32'({endstop_hit, start_fail}), 32'd0);

        // Randomised back-to-back moves, some null
        for (int i = 0; i < 8; i++) begin
            drv_lat = $urandom_range(0, 4);
            drv_len = $urandom_range(1, 6);
            c = rnd_cmd();
            if ($urandom_range(0, 4) == 0) begin
                c.step_1 = {c.step_1[31], 31'd0};
                c.step_2 = {c.step_2[31], 31'd0};
            end
            push_cmd(c, 1'b1);
        end
        wait_cond(W_IDLE, "t7_idle");
        while (exp_q.size() > 0 && is_null_move(exp_q[0])) begin
            void'(exp_q.pop_front());
            exp_done++;
        end
        check("t7_moves_done", 32'(moves_done), 32'(exp_done));
        check("t7_queue_drained", 32'(exp_q.size()), 32'd0);

        // Asynchronous reset in the middle of a move
        drv_len = 20;
        push_cmd(rnd_cmd(), 1'b1);
        push_cmd(rnd_cmd(), 1'b1);
        wait_cond(W_RUN, "t8_running");
        #2 rst_n = 1'b0;
        #1;
        check("t8_start_low", 32'(start_driving), 32'd0);
        check("t8_step_in_1", stepper_step_in_1, 32'd0);
        check("t8_speed_1", stepper_speed_1, 32'd0);
        check("t8_step_in_2", stepper_step_in_2, 32'd0);
        check("t8_speed_2", stepper_speed_2, 32'd0);
        check("t8_moves_done", 32'(moves_done), 32'd0);
        check("t8_fifo_count", 32'(fifo_count), 32'd0);
        exp_q.delete();
        exp_done = 0;
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        check("t8_ready_after", 32'(cmd_ready), 32'd1);

        // Recovery after reset
        drv_lat = 1; drv_len = 2;
        for (int i = 0; i < 3; i++) push_cmd(rnd_cmd(), 1'b1);
        wait_cond(W_IDLE, "t9_idle");
        check("t9_moves_done", 32'(moves_done), 32'(exp_done));
        check("t9_three_moves", 32'(exp_done), 32'd3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
